// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and constants for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/fs_cell.sv
// ============================================================================
// Module      : fs_cell
// Description : Combinational 1-bit full subtractor (a - b - c).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fs_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ c;
    assign bo = (~a & b) | (c & ~(a ^ b));

endmodule : fs_cell

`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial WIDTH-bit subtractor, LSB first, start/busy/done.
//               Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_run;
    logic               w_fin;
    logic               w_busy;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_borrow;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_cell_d;
    logic               w_cell_bo;

    fs_cell u_fs_cell (
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .c  (r_borrow),
        .d  (w_cell_d),
        .bo (w_cell_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_run        = 1'b0;
        w_fin        = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_run  = 1'b1;
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next_state = FIN;
                end
            end
            FIN: begin
                // Busy stays high until the result is published on this edge.
                w_fin        = 1'b1;
                w_busy       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a_sh   <= a_in;
                r_b_sh   <= b_in;
                r_borrow <= bin;
                r_res    <= '0;
                r_cnt    <= '0;
            end else if (w_run) begin
                // Each new difference bit enters at the MSB, so after WIDTH
                // shifts the first (LSB) bit has arrived at position 0.
                r_res    <= {w_cell_d, r_res[WIDTH-1:1]};
                r_borrow <= w_cell_bo;
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end else if (w_fin) begin
                r_diff <= r_res;
                r_bout <= r_borrow;
                r_done <= 1'b1;
            end
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are shifted out of the operand registers during RUN.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_msb <= a_in[WIDTH-1];
                r_b_msb <= b_in[WIDTH-1];
            end else if (w_fin) begin
                r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_res[WIDTH-1]);
            end
        end
    end

    assign ovf = r_ovf;
`endif

endmodule : serial_sub_ctrl

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
// ============================================================================
// Module      : tb_serial_sub_ctrl
// Description : Self-checking bench for serial_sub_ctrl (WIDTH=8) against an
//               integer-arithmetic reference model. Honours SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub_ctrl;

    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction, unsigned and signed views.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c);
        int u;
        int s;
        logic [W-1:0] d;
        logic bo;
        logic ov;
        u  = int'(a) - int'(b) - int'(c);
        s  = int'($signed(a)) - int'($signed(b)) - int'(c);
        d  = u[W-1:0];
        bo = (u < 0);
        ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
        return {ov, bo, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation from IDLE and checks latency, result and pulse width.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic check_ovf);
        logic [W+1:0] exp;
        int  cycles;
        bit  seen;
        bit  busy_ok;
        exp   = ref_sub(a, b, c);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        bin   = c;
        tick();
        start   = 1'b0;
        a_in    = W'($urandom);
        b_in    = W'($urandom);
        bin     = 1'($urandom);
        cycles  = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && cycles < 4 * W) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            cycles++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL op_timeout a=%h b=%h bin=%0d: no done within %0d cycles", a, b, c, 4 * W);
            return;
        end
        checks++;
        if (cycles !== LAT) begin
            errors++;
            $display("FAIL latency a=%h b=%h: got %0d cycles, expected %0d", a, b, cycles, LAT);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL busy_during_op a=%h b=%h: busy dropped before done, expected 1", a, b);
        end
        checks++;
        if (diff !== exp[W-1:0] || bout !== exp[W] || busy !== 1'b0) begin
            errors++;
            $display("FAIL result a=%h b=%h bin=%0d: diff=%h bout=%0d busy=%0d, expected diff=%h bout=%0d busy=0",
                     a, b, c, diff, bout, busy, exp[W-1:0], exp[W]);
        end
`ifdef SERIAL_SUB_OVF_EN
        if (check_ovf) begin
            checks++;
            if (ovf !== exp[W+1]) begin
                errors++;
                $display("FAIL ovf a=%h b=%h bin=%0d: ovf=%0d, expected %0d", a, b, c, ovf, exp[W+1]);
            end
        end
`else
        if (check_ovf) begin end
`endif
        tick();
        checks++;
        if (done !== 1'b0 || diff !== exp[W-1:0] || bout !== exp[W]) begin
            errors++;
            $display("FAIL done_pulse_hold a=%h b=%h: done=%0d diff=%h bout=%0d, expected done=0 diff=%h bout=%0d",
                     a, b, done, diff, bout, exp[W-1:0], exp[W]);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        bin   = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%0d done=%0d diff=%h bout=%0d, expected all 0",
                     busy, done, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%0d, expected 0", ovf);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        do_op(8'h05, 8'h03, 1'b0, 1'b1);
        do_op(8'h03, 8'h05, 1'b0, 1'b1);
        do_op(8'h00, 8'h00, 1'b1, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b1);
        do_op(8'hFF, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_ovf();
        do_op(8'h80, 8'h01, 1'b0, 1'b1);
        do_op(8'h7F, 8'hFF, 1'b0, 1'b1);
        do_op(8'h10, 8'h01, 1'b0, 1'b1);
        do_op(8'h80, 8'h00, 1'b1, 1'b1);
        do_op(8'h00, 8'h80, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 2500; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'h7F;
            do_op(a, b, 1'($urandom), 1'b1);
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        bit busy_ok;
        start = 1'b1;
        a_in  = 8'h05;
        b_in  = 8'h03;
        bin   = 1'b0;
        tick();
        start   = 1'b0;
        dones   = 0;
        busy_ok = 1'b1;
        for (int t = 1; t <= 3 * W; t++) begin
            if (t >= 2 && t <= 6) begin
                start = 1'b1;
                a_in  = 8'hAA;
                b_in  = 8'h11;
            end else begin
                start = 1'b0;
            end
            if (t <= W && busy !== 1'b1) busy_ok = 1'b0;
            tick();
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (diff !== 8'h02 || bout !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_start_result: diff=%h bout=%0d, expected diff=02 bout=0", diff, bout);
                end
            end
        end
        checks++;
        if (dones !== 1 || !busy_ok) begin
            errors++;
            $display("FAIL ignore_start: dones=%0d busy_ok=%0d, expected dones=1 busy_ok=1", dones, busy_ok);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        start = 1'b1;
        a_in  = 8'h5A;
        b_in  = 8'h33;
        bin   = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%0d done=%0d diff=%h bout=%0d, expected all 0",
                     busy, done, diff, bout);
        end
        dones = 0;
        for (int t = 0; t < 2 * W; t++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: dones=%0d busy=%0d, expected 0 and 0", dones, busy);
        end
        do_op(8'h10, 8'h01, 1'b0, 1'b1);
    endtask

    // start held high: accepts at edges 0, W+2, 2(W+2), ...; operands change every cycle.
    task automatic test_back_to_back();
        localparam int OPS = 20;
        localparam int TOT = OPS * (W + 2);
        logic [W-1:0] ta [TOT];
        logic [W-1:0] tb [TOT];
        logic         tc [TOT];
        logic [W+1:0] exp;
        bit           exp_done;
        int           idx;
        start = 1'b1;
        for (int t = 0; t < TOT; t++) begin
            ta[t] = W'($urandom);
            tb[t] = W'($urandom);
            tc[t] = 1'($urandom);
            a_in  = ta[t];
            b_in  = tb[t];
            bin   = tc[t];
            tick();
            exp_done = (t >= LAT) && (((t - LAT) % (W + 2)) == 0);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL b2b_done t=%0d: done=%0d, expected %0d", t, done, exp_done);
            end
            if (exp_done) begin
                idx = t - LAT;
                exp = ref_sub(ta[idx], tb[idx], tc[idx]);
                checks++;
                if (diff !== exp[W-1:0] || bout !== exp[W]) begin
                    errors++;
                    $display("FAIL b2b_result t=%0d a=%h b=%h bin=%0d: diff=%h bout=%0d, expected diff=%h bout=%0d",
                             t, ta[idx], tb[idx], tc[idx], diff, bout, exp[W-1:0], exp[W]);
                end
            end
        end
        start = 1'b0;
        repeat (2 * W) tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ovf();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_sub_ctrl

`default_nettype wire
